lut_sweep_checker: RTL and testbench

//  Sequencer/checker for the 5-in/2-out minimised lookup circuit. On start, it

---
 rtl/lut_sweep_checker.sv | 113 +++++++++++
 tb/tb_lut_sweep_checker.sv | 151 +++++++++++++++
 2 files changed

// File: rtl/lut_sweep_checker.sv
// lut_sweep_checker: sweeps every input code through a lookup circuit and
// checks the returned y against golden masks, allowing for circuit latency.
module lut_sweep_checker #(
    parameter int                  IN_W  = 5,
    parameter logic [2**IN_W-1:0]  GOLD0 = 32'h6af7ceaa,
    parameter logic [2**IN_W-1:0]  GOLD1 = 32'h102e19a7,
    parameter int                  LAT   = 0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            abort,
    output logic [IN_W-1:0] x_out,
    input  logic [1:0]      y_in,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [IN_W:0]   err_count,
    output logic [IN_W-1:0] first_err_idx,
    output logic            first_err_valid
);
    typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;
    state_t          state_q, state_d;
    logic [IN_W-1:0] cnt_q, cnt_d, fi_q, fi_d, chk_c;
    logic [1:0]      dcnt_q, dcnt_d;
    logic [IN_W:0]   err_q, err_d;
    logic            fv_q, fv_d, pass_q, pass_d;
    logic            chk_v, mism, clr, kill;

    assign clr  = (state_q == IDLE) && start;
    assign kill = (state_q == SWEEP || state_q == DRAIN) && abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dcnt_d  = '0;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (start) state_d = SWEEP;
            end
            SWEEP: begin
                if (&cnt_q) state_d = (LAT > 0) ? DRAIN : DONE;
                else cnt_d = cnt_q + 1'b1;
            end
            DRAIN: begin
                dcnt_d = dcnt_q + 2'd1;
                if (dcnt_q == 2'(LAT - 1)) state_d = DONE;
            end
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    // Codes travel alongside the circuit so each y_in is matched to the code
    // that produced it; an abort empties the pipe so no stale check survives.
    if (LAT == 0) begin : g_comb
        assign chk_v = (state_q == SWEEP);
        assign chk_c = cnt_q;
    end else begin : g_pipe
        logic [LAT-1:0]           pv_q;
        logic [LAT-1:0][IN_W-1:0] pc_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                pv_q <= '0;
                pc_q <= '0;
            end else begin
                pv_q[0] <= (state_q == SWEEP) && !kill;
                pc_q[0] <= cnt_q;
                for (int i = LAT - 1; i > 0; i--) begin
                    pv_q[i] <= pv_q[i-1] && !kill;
                    pc_q[i] <= pc_q[i-1];
                end
            end
        end
        assign chk_v = pv_q[LAT-1];
        assign chk_c = pc_q[LAT-1];
    end

    assign mism   = chk_v && (y_in != {GOLD1[chk_c], GOLD0[chk_c]});
    assign err_d  = clr ? '0 : err_q + {{IN_W{1'b0}}, mism};
    assign fv_d   = !clr && (fv_q || mism);
    assign fi_d   = clr ? '0 : (mism && !fv_q) ? chk_c : fi_q;
    assign pass_d = (clr || kill) ? 1'b0 : (state_d == DONE) ? (err_d == '0) : pass_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            dcnt_q  <= '0;
            err_q   <= '0;
            fi_q    <= '0;
            fv_q    <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dcnt_q  <= dcnt_d;
            err_q   <= err_d;
            fi_q    <= fi_d;
            fv_q    <= fv_d;
            pass_q  <= pass_d;
        end
    end

    assign x_out           = (state_q == IDLE) ? '0 : cnt_q;
    assign busy            = (state_q == SWEEP) || (state_q == DRAIN);
    assign done            = (state_q == DONE);
    assign pass            = pass_q;
    assign err_count       = err_q;
    assign first_err_idx   = fi_q;
    assign first_err_valid = fv_q;
endmodule

// File: tb/tb_lut_sweep_checker.sv
// tb_lut_sweep_checker: directed sweeps against LAT=0 and LAT=2 checker instances.
module tb_lut_sweep_checker;
    localparam logic [31:0] G0 = 32'h6af7ceaa;
    localparam logic [31:0] G1 = 32'h102e19a7;

    logic       clk = 0, rst = 1, start = 0, abort = 0;
    int         mode = 0;
    logic [4:0] x0, x2, fi0, fi2;
    logic [1:0] y0, y2, r01, r02, r21, r22;
    logic       busy0, busy2, done0, done2, pass0, pass2, fv0, fv2;
    logic [5:0] err0, err2;
    int         nvec = 0, nerr = 0;
    int         dcyc, dn, bc;

    always #5 clk = ~clk;

    function automatic logic [1:0] g(input logic [4:0] x);
        return {G1[x], G0[x]};
    endfunction

    // Circuit models: mode 0 golden, 1 y[1] flipped at 9/20, 2 stuck 00, 3 two-stage registered.
    always_ff @(posedge clk) begin
        r01 <= g(x0);
        r02 <= r01;
        r21 <= g(x2);
        r22 <= r21;
    end
    always_comb begin
        y0 = g(x0);
        if (mode == 1 && (x0 == 5'd9 || x0 == 5'd20)) y0 = g(x0) ^ 2'b10;
        if (mode == 2) y0 = 2'b00;
        if (mode == 3) y0 = r02;
        y2 = r22;
    end

    lut_sweep_checker #(.LAT(0)) u0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_out(x0), .y_in(y0),
        .busy(busy0), .done(done0), .pass(pass0), .err_count(err0),
        .first_err_idx(fi0), .first_err_valid(fv0));
    lut_sweep_checker #(.LAT(2)) u2 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .x_out(x2), .y_in(y2),
        .busy(busy2), .done(done2), .pass(pass2), .err_count(err2),
        .first_err_idx(fi2), .first_err_valid(fv2));

    task automatic chk(input string tag, input int got, input int exp);
        nvec++;
        if (got != exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Runs a 45-cycle window from a start edge; cycle 0 is the first cycle after it.
    task automatic sweep(input bit s, input bit hold, input int ab, input int ra,
                         output int d_cyc, output int d_n, output int b_c);
        start = 1;
        @(posedge clk); #1;
        d_cyc = -1; d_n = 0; b_c = 0;
        for (int c = 0; c < 45; c++) begin
            if (s ? busy2 : busy0) b_c++;
            if (s ? done2 : done0) begin
                d_n++;
                if (d_cyc < 0) d_cyc = c;
            end
            if (!s && !hold && ab < 0 && ra < 0 && (c == 0 || c == 17 || c == 31))
                chk($sformatf("x_out@%0d", c), x0, c);
            start = hold && (c < 9 || c == 10);
            abort = (c == ab);
            if (c == ra) begin
                rst = 1; #1;
                chk("rst_busy", busy0, 0);
                chk("rst_x", x0, 0);
                chk("rst_err", err0, 0);
                chk("rst_fv", fv0, 0);
                chk("rst_fi", fi0, 0);
                chk("rst_done", done0, 0);
                rst = 0;
            end
            @(posedge clk); #1;
        end
        start = 0; abort = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 0;
        chk("reset_busy", busy0, 0);
        chk("reset_done", done0, 0);
        chk("reset_pass", pass0, 0);
        chk("reset_err", err0, 0);
        chk("reset_x", x0, 0);
        chk("reset_fv", fv0, 0);

        mode = 0;
        sweep(0, 0, -1, -1, dcyc, dn, bc);
        chk("t1_busy_cycles", bc, 32);
        chk("t1_done_cycle", dcyc, 32);
        chk("t1_done_count", dn, 1);
        chk("t1_pass", pass0, 1);
        chk("t1_err", err0, 0);
        chk("t1_fv", fv0, 0);

        mode = 1;
        sweep(0, 0, -1, -1, dcyc, dn, bc);
        chk("t2_err", err0, 2);
        chk("t2_fi", fi0, 9);
        chk("t2_fv", fv0, 1);
        chk("t2_pass", pass0, 0);

        mode = 3;
        sweep(1, 0, -1, -1, dcyc, dn, bc);
        chk("t3_lat2_done_cycle", dcyc, 34);
        chk("t3_lat2_busy_cycles", bc, 34);
        chk("t3_lat2_pass", pass2, 1);
        chk("t3_lat2_err", err2, 0);
        chk("t3_lat0_err_nonzero", err0 != 0, 1);
        chk("t3_lat0_pass", pass0, 0);

        mode = 2;
        sweep(0, 0, -1, -1, dcyc, dn, bc);
        chk("t4_err", err0, 26);
        chk("t4_fi", fi0, 0);
        chk("t4_fv", fv0, 1);
        chk("t4_pass", pass0, 0);

        mode = 0;
        sweep(0, 1, -1, -1, dcyc, dn, bc);
        chk("t5_done_count", dn, 1);
        chk("t5_done_cycle", dcyc, 32);
        chk("t5_busy_cycles", bc, 32);
        chk("t5_pass", pass0, 1);

        sweep(0, 0, 15, -1, dcyc, dn, bc);
        chk("t6_abort_busy_cycles", bc, 16);
        chk("t6_abort_done_count", dn, 0);
        chk("t6_abort_pass", pass0, 0);
        chk("t6_abort_busy_end", busy0, 0);

        sweep(0, 0, -1, 20, dcyc, dn, bc);
        chk("t6_rst_done_count", dn, 0);
        chk("t6_rst_pass", pass0, 0);

        sweep(0, 0, -1, -1, dcyc, dn, bc);
        chk("t6_clean_done_cycle", dcyc, 32);
        chk("t6_clean_pass", pass0, 1);
        chk("t6_clean_err", err0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
